// File: rtl/led7seg_pkg.sv
// Shared definitions for the scanned 7-segment / 74HC595 display driver:
// segment codes (common-anode form), scan FSM states and shift word width.
package led7seg_pkg;

  localparam int WORD_W = 16;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO
  } scan_state_e;

  function automatic logic [7:0] seg_ca(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/led7seg_hex_decode.sv
// Combinational digit-code to segment-byte decoder (bit order DP G F E D C B A),
// with blanking, decimal point and selectable segment polarity.
module led7seg_hex_decode
  import led7seg_pkg::*;
#(
  parameter int HEX_EN       = 0,
  parameter int COMMON_ANODE = 1
) (
  input  logic [3:0] code_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] seg_ca_w;

  // A blanked digit keeps its decimal point; polarity is applied last.
  always_comb begin
    seg_ca_w = SEG_BLANK;
    if (!blank_i && ((code_i < 4'd10) || (HEX_EN != 0))) begin
      seg_ca_w = seg_ca(code_i);
    end
    if (dp_i) begin
      seg_ca_w[7] = 1'b0;
    end
    seg_o = (COMMON_ANODE != 0) ? seg_ca_w : ~seg_ca_w;
  end

endmodule

// File: rtl/led7seg_scan_hc595.sv
// Multi-digit 7-segment scanner that serialises {seg, sel} words, one digit
// at a time, into two chained 74HC595 registers via SER/SRCLK/RCLK.
module led7seg_scan_hc595
  import led7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCLK_DIV       = 2,
  parameter int HEX_EN         = 0,
  parameter int COMMON_ANODE   = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    blank_lz,
  output logic                    hc_ser,
  output logic                    hc_srclk,
  output logic                    hc_rclk,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [WORD_W-1:0]       shift_q, shift_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    blz_q, blz_d;
  logic                    frame_done_q, frame_done_d;

  logic                    use_live;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic                    src_blz;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic                    lz_blank;
  logic                    leading;
  logic [7:0]              sel_raw;
  logic [7:0]              sel;
  logic [7:0]              seg;
  logic [WORD_W-1:0]       word;
  logic                    div_last;

  // Digit 0's LOAD reads the live inputs (it is the cycle the snapshot is
  // taken); every later digit of the frame reads the snapshot.
  assign use_live   = (state_q == ST_LOAD) && (idx_q == '0);
  assign src_digits = use_live ? digits : digits_q;
  assign src_dp     = use_live ? dp : dp_q;
  assign src_blz    = use_live ? blank_lz : blz_q;

  always_comb begin
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    sel_raw  = 8'd0;
    lz_blank = 1'b0;
    leading  = src_blz;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_code   = src_digits[4*k +: 4];
        cur_dp     = src_dp[k];
        sel_raw[k] = 1'b1;
      end
    end
    // Walk down from the MSD; a digit is leading-zero blank only while every
    // digit at or above it is zero. Digit 0 is never considered.
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (src_digits[4*k +: 4] != 4'd0) begin
        leading = 1'b0;
      end
      if (idx_q == IDX_W'(k)) begin
        lz_blank = leading;
      end
    end
    sel = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
  end

  led7seg_hex_decode #(
    .HEX_EN       (HEX_EN),
    .COMMON_ANODE (COMMON_ANODE)
  ) u_decode (
    .code_i  (cur_code),
    .dp_i    (cur_dp),
    .blank_i (lz_blank),
    .seg_o   (seg)
  );

  assign word     = {seg, sel};
  assign div_last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      blz_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      blz_q        <= blz_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    blz_d        = blz_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (enable) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d = word;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT_LO;
        if (idx_q == '0) begin
          digits_d = digits;
          dp_d     = dp;
          blz_d    = blank_lz;
        end
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          cnt_d   = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = ST_LATCH_HI;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            state_d = ST_SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH_HI: begin
        if (div_last) begin
          cnt_d   = '0;
          state_d = ST_LATCH_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LATCH_LO: begin
        if (div_last) begin
          cnt_d        = '0;
          frame_done_d = (idx_q == LAST_IDX);
          if (!enable || (idx_q == LAST_IDX)) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          state_d = enable ? ST_LOAD : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pins are decoded from the registered state so reset clears them at once.
  always_comb begin
    hc_ser   = 1'b0;
    hc_srclk = 1'b0;
    hc_rclk  = 1'b0;
    case (state_q)
      ST_LOAD:     hc_ser = word[WORD_W-1];
      ST_SHIFT_LO: hc_ser = shift_q[WORD_W-1];
      ST_SHIFT_HI: begin
        hc_ser   = shift_q[WORD_W-1];
        hc_srclk = 1'b1;
      end
      ST_LATCH_HI: hc_rclk = 1'b1;
      default: ;
    endcase
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_scan_hc595.sv
// Scoreboard bench: expected latched words are queued per frame; a monitor
// rebuilds each 16-bit word from SER/SRCLK and compares it on every RCLK pulse.
module tb_led7seg_scan_hc595;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        enA   = 1'b0;
  logic        enB   = 1'b0;
  logic        blz   = 1'b0;
  logic [15:0] dig   = 16'h0000;
  logic [3:0]  dpv   = 4'b0000;
  logic        serA, srclkA, rclkA, fdA;
  logic        serB, srclkB, rclkB, fdB;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  logic [15:0] expQ0[$];
  logic [15:0] expQ1[$];

  logic        prevSer[2];
  logic        prevSrclk[2];
  logic        prevRclk[2];
  logic        prevFd[2];
  logic [15:0] sh[2];
  int          edgeCnt[2];
  int          lastRise[2];
  int          riseGap[2];

  always #5 clk = ~clk;

  led7seg_scan_hc595 #(
    .NUM_DIGITS(4), .SCLK_DIV(2), .HEX_EN(0), .COMMON_ANODE(1), .SEL_ACTIVE_LOW(0)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .enable(enA), .digits(dig), .dp(dpv), .blank_lz(blz),
    .hc_ser(serA), .hc_srclk(srclkA), .hc_rclk(rclkA), .frame_done(fdA)
  );

  led7seg_scan_hc595 #(
    .NUM_DIGITS(4), .SCLK_DIV(2), .HEX_EN(1), .COMMON_ANODE(1), .SEL_ACTIVE_LOW(0)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .enable(enB), .digits(dig), .dp(dpv), .blank_lz(blz),
    .hc_ser(serB), .hc_srclk(srclkB), .hc_rclk(rclkB), .frame_done(fdB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input int u);
    miscompares++;
    $display("[TB] FAIL %s (unit %0d): got violation, expected none", name, u);
  endtask

  function automatic logic [3:0] unitOut(input int u);
    return (u == 0) ? {serA, srclkA, rclkA, fdA} : {serB, srclkB, rclkB, fdB};
  endfunction

  task automatic monitorStep(input int u, input logic ser, input logic srclk,
                             input logic rclk, input logic fd);
    logic [15:0] e;
    int qs;
    if (srclk && prevSrclk[u] && (ser !== prevSer[u])) reportFail("ser_changed_while_srclk_high", u);
    if (srclk && rclk) reportFail("srclk_rclk_overlap", u);
    if (fd && prevFd[u]) reportFail("frame_done_longer_than_one_cycle", u);
    if (srclk && !prevSrclk[u]) begin
      sh[u] = {sh[u][14:0], ser};
      edgeCnt[u]++;
    end
    if (rclk && !prevRclk[u]) begin
      checkOutput($sformatf("srclk_edges_per_latch_u%0d", u), 32'(edgeCnt[u]), 32'd16);
      edgeCnt[u]  = 0;
      riseGap[u]  = cyc - lastRise[u];
      lastRise[u] = cyc;
      qs = (u == 0) ? expQ0.size() : expQ1.size();
      if (qs == 0) begin
        reportFail("unexpected_latch", u);
      end else begin
        if (u == 0) e = expQ0.pop_front();
        else        e = expQ1.pop_front();
        checkOutput($sformatf("latched_word_u%0d", u), 32'(sh[u]), 32'(e));
      end
    end
    prevSer[u]   = ser;
    prevSrclk[u] = srclk;
    prevRclk[u]  = rclk;
    prevFd[u]    = fd;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        prevSer[u] = 1'b0; prevSrclk[u] = 1'b0; prevRclk[u] = 1'b0; prevFd[u] = 1'b0;
        sh[u] = 16'h0000; edgeCnt[u] = 0;
      end
    end else begin
      monitorStep(0, serA, srclkA, rclkA, fdA);
      monitorStep(1, serB, srclkB, rclkB, fdB);
    end
  end

  task automatic pushExp(input int u, input logic [15:0] w);
    if (u == 0) expQ0.push_back(w);
    else        expQ1.push_back(w);
  endtask

  function automatic int qSize(input int u);
    return (u == 0) ? expQ0.size() : expQ1.size();
  endfunction

  task automatic waitFd(input int u, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    for (int i = 1; i <= 2000 && !hit; i++) begin
      @(negedge clk);
      n   = i;
      hit = (u == 0) ? fdA : fdB;
    end
    if (!hit) reportFail("frame_done_timeout", u);
  endtask

  task automatic waitRclk(input int u, input int count);
    int seen;
    logic prev;
    seen = 0;
    prev = (u == 0) ? rclkA : rclkB;
    for (int i = 0; i < 2000 && seen < count; i++) begin
      @(negedge clk);
      if (((u == 0) ? rclkA : rclkB) && !prev) seen++;
      prev = (u == 0) ? rclkA : rclkB;
    end
    if (seen < count) reportFail("rclk_timeout", u);
  endtask

  // Called from idle or on the sample where frame_done is seen (digit 0 LOAD).
  task automatic applyStimulus(input int u, input logic [15:0] d, input logic [3:0] p,
                               input logic b, input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3, output int n);
    dig = d; dpv = p; blz = b;
    pushExp(u, w0); pushExp(u, w1); pushExp(u, w2); pushExp(u, w3);
    if (u == 0) enA = 1'b1;
    else        enB = 1'b1;
    waitFd(u, n);
    checkOutput($sformatf("frame_words_drained_u%0d", u), 32'(qSize(u)), 32'd0);
  endtask

  task automatic drainToIdle(input int u);
    bit sawFd;
    logic [3:0] bad;
    sawFd = 1'b0;
    bad   = 4'h0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (((u == 0) ? fdA : fdB)) sawFd = 1'b1;
    end
    checkOutput($sformatf("no_frame_done_after_stop_u%0d", u), 32'(sawFd), 32'd0);
    checkOutput($sformatf("stop_words_drained_u%0d", u), 32'(qSize(u)), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad = bad | unitOut(u);
    end
    checkOutput($sformatf("idle_outputs_after_stop_u%0d", u), 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    logic [3:0] bad;
    bit hit;

    #2 rst_n = 1'b0;
    #1 checkOutput("reset_outputs", 32'({unitOut(0), unitOut(1)}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 4'h0;
    repeat (40) begin
      @(negedge clk);
      bad = bad | unitOut(0) | unitOut(1);
    end
    checkOutput("idle_outputs_enable_low", 32'(bad), 32'd0);

    $display("[TB] basic frame and decode vectors");
    applyStimulus(0, 16'h1234, 4'b0000, 1'b0, 16'h9901, 16'hB002, 16'hA404, 16'hF908, n);
    applyStimulus(0, 16'h1234, 4'b0000, 1'b0, 16'h9901, 16'hB002, 16'hA404, 16'hF908, n);
    checkOutput("frame_period_cycles", 32'(n), 32'd276);
    checkOutput("digit_period_cycles", 32'(riseGap[0]), 32'd69);
    applyStimulus(0, 16'h0005, 4'b0000, 1'b1, 16'h9201, 16'hFF02, 16'hFF04, 16'hFF08, n);
    applyStimulus(0, 16'h0005, 4'b0000, 1'b0, 16'h9201, 16'hC002, 16'hC004, 16'hC008, n);
    applyStimulus(0, 16'h0000, 4'b0000, 1'b1, 16'hC001, 16'hFF02, 16'hFF04, 16'hFF08, n);
    applyStimulus(0, 16'h00AF, 4'b0001, 1'b0, 16'h7F01, 16'hFF02, 16'hC004, 16'hC008, n);
    applyStimulus(0, 16'h0406, 4'b1000, 1'b1, 16'h8201, 16'hC002, 16'h9904, 16'h7F08, n);
    applyStimulus(0, 16'h9870, 4'b0010, 1'b1, 16'hC001, 16'h7802, 16'h8004, 16'h9008, n);

    $display("[TB] input change during digit 2 must wait for next frame");
    dig = 16'h1234; dpv = 4'b0000; blz = 1'b0;
    pushExp(0, 16'h9901); pushExp(0, 16'hB002); pushExp(0, 16'hA404); pushExp(0, 16'hF908);
    waitRclk(0, 2);
    repeat (10) @(negedge clk);
    dig = 16'h5678;
    waitFd(0, n);
    checkOutput("snapshot_frame_drained", 32'(qSize(0)), 32'd0);
    applyStimulus(0, 16'h5678, 4'b0000, 1'b0, 16'h8001, 16'hF802, 16'h8204, 16'h9208, n);

    $display("[TB] enable dropped during digit 1");
    pushExp(0, 16'h8001); pushExp(0, 16'hF802);
    waitRclk(0, 1);
    repeat (10) @(negedge clk);
    enA = 1'b0;
    drainToIdle(0);
    applyStimulus(0, 16'h1234, 4'b0000, 1'b0, 16'h9901, 16'hB002, 16'hA404, 16'hF908, n);

    $display("[TB] reset pulse during SHIFT_HI");
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = srclkA;
    end
    if (!hit) reportFail("srclk_high_timeout", 0);
    rst_n = 1'b0;
    #1 checkOutput("reset_mid_shift_outputs", 32'(unitOut(0)), 32'd0);
    expQ0.delete();
    enA = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 16'h1234, 4'b0000, 1'b0, 16'h9901, 16'hB002, 16'hA404, 16'hF908, n);
    pushExp(0, 16'h9901);
    enA = 1'b0;
    drainToIdle(0);

    $display("[TB] hex decode unit");
    applyStimulus(1, 16'h00AF, 4'b0001, 1'b0, 16'h0E01, 16'h8802, 16'hC004, 16'hC008, n);
    applyStimulus(1, 16'hCDEB, 4'b0000, 1'b0, 16'h8301, 16'h8602, 16'hA104, 16'hC608, n);
    pushExp(1, 16'h8301);
    enB = 1'b0;
    drainToIdle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
